// File: rtl/led_display_row_driver.sv
// HUB75-style row driver: captures one row, shifts it out MSB column first,
// latches it onto the panel row address and then enables the LEDs.
module led_display_row_driver #(
  parameter int SYS_CLK_FREQ   = 100_000_000,
  parameter int BCLK_FREQ      = 21_000_000,
  parameter int NUM_COL_PIXELS = 64,
  parameter int DISPLAY_CYCLES = 256
) (
  input  logic                        clk_in,
  input  logic                        reset_in,
  input  logic [6*NUM_COL_PIXELS-1:0] row_in,
  input  logic                        row_valid_in,
  output logic                        row_ready_out,
  input  logic [3:0]                  row_address_in,
  output logic [2:0]                  rgb_top_out,
  output logic [2:0]                  rgb_bot_out,
  output logic                        bclk_out,
  output logic                        latch_out,
  output logic                        oe_n_out,
  output logic [3:0]                  addr_out
);

  localparam int N          = NUM_COL_PIXELS;
  localparam int HALF_RAW   = SYS_CLK_FREQ / (2 * BCLK_FREQ);
  localparam int HALF       = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int COL_PERIOD = 2 * HALF;
  localparam int CNT_MAX    = (COL_PERIOD > DISPLAY_CYCLES) ? COL_PERIOD : DISPLAY_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int COL_W      = (N > 1) ? $clog2(N) : 1;

  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(COL_PERIOD - 1);
  localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISPLAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(HALF);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_DISPLAY} state_t;

  state_t             r_state;
  logic [6*N-1:0]     r_row;
  logic [3:0]         r_addr;
  logic [COL_W-1:0]   r_col;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_bclk;
  logic               r_latch;
  logic               r_oe_n;
  logic [3:0]         r_addr_out;
  logic [5:0]         r_rgb;

  logic [CNT_W-1:0]   w_cnt_inc;
  logic [COL_W-1:0]   w_next_idx;
  logic [5:0]         w_first_col;
  logic [5:0]         w_reg_cols [N];

  // Row layout, MSB first: top.red, top.green, top.blue, bot.red, bot.green, bot.blue.
  // Each column packs to {bot.b, bot.g, bot.r, top.b, top.g, top.r}.
  for (genvar gi = 0; gi < N; gi++) begin : g_col
    assign w_reg_cols[gi] = {r_row[gi], r_row[N+gi], r_row[2*N+gi],
                             r_row[3*N+gi], r_row[4*N+gi], r_row[5*N+gi]};
  end

  assign w_first_col = {row_in[N-1], row_in[2*N-1], row_in[3*N-1],
                        row_in[4*N-1], row_in[5*N-1], row_in[6*N-1]};
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  // r_col counts shifted columns upward; the physical column is LAST_COL - r_col.
  assign w_next_idx  = LAST_COL - r_col - COL_W'(1);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_col      <= '0;
      r_cnt      <= '0;
      r_bclk     <= 1'b0;
      r_latch    <= 1'b0;
      r_oe_n     <= 1'b1;
      r_addr_out <= '0;
      r_rgb      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (row_valid_in) begin
            r_row   <= row_in;
            r_addr  <= row_address_in;
            r_col   <= '0;
            r_cnt   <= '0;
            r_bclk  <= 1'b0;
            r_rgb   <= w_first_col;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_cnt == COL_LAST) begin
            r_cnt  <= '0;
            r_bclk <= 1'b0;
            if (r_col == LAST_COL) begin
              r_rgb      <= '0;
              r_latch    <= 1'b1;
              r_addr_out <= r_addr;
              r_state    <= S_LATCH;
            end else begin
              r_col <= r_col + COL_W'(1);
              r_rgb <= w_reg_cols[w_next_idx];
            end
          end else begin
            r_cnt  <= w_cnt_inc;
            r_bclk <= (w_cnt_inc >= HALF_CNT);
          end
        end
        S_LATCH: begin
          if (r_cnt == COL_LAST) begin
            r_cnt   <= '0;
            r_latch <= 1'b0;
            r_oe_n  <= 1'b0;
            r_state <= S_DISPLAY;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_DISPLAY: begin
          if (r_cnt == DISP_LAST) begin
            r_cnt   <= '0;
            r_oe_n  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gated by reset so ready is low during reset yet high the first cycle after it.
  assign row_ready_out = (r_state == S_IDLE) && !reset_in;
  assign rgb_top_out   = r_rgb[2:0];
  assign rgb_bot_out   = r_rgb[5:3];
  assign bclk_out      = r_bclk;
  assign latch_out     = r_latch;
  assign oe_n_out      = r_oe_n;
  assign addr_out      = r_addr_out;

endmodule

// File: tb/tb_led_display_row_driver.sv
// Scoreboard bench: stimulus queues expected columns/latch/display per row,
// a negedge monitor pops and compares as the panel signals appear.
`timescale 1ns/1ps
module tb_led_display_row_driver;

  localparam int N  = 64;
  localparam int H  = 2;
  localparam int D  = 256;
  localparam int FD = 32;
  localparam int K_COL = 0, K_LATCH = 1, K_DISP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_in;
  logic [6*N-1:0] row_in;
  logic           row_valid_in;
  logic           row_ready_out;
  logic [3:0]     row_address_in;
  logic [2:0]     rgb_top_out, rgb_bot_out;
  logic           bclk_out, latch_out, oe_n_out;
  logic [3:0]     addr_out;

  logic [6*N-1:0] f_row;
  logic           f_valid, f_ready;
  logic [3:0]     f_addr_in;
  logic [2:0]     f_top, f_bot;
  logic           f_bclk, f_latch, f_oe_n;
  logic [3:0]     f_addr_out;

  led_display_row_driver dut (
    .clk_in(clk), .reset_in(reset_in), .row_in(row_in), .row_valid_in(row_valid_in),
    .row_ready_out(row_ready_out), .row_address_in(row_address_in),
    .rgb_top_out(rgb_top_out), .rgb_bot_out(rgb_bot_out), .bclk_out(bclk_out),
    .latch_out(latch_out), .oe_n_out(oe_n_out), .addr_out(addr_out)
  );

  led_display_row_driver #(.BCLK_FREQ(50_000_000), .DISPLAY_CYCLES(FD)) dut_fast (
    .clk_in(clk), .reset_in(reset_in), .row_in(f_row), .row_valid_in(f_valid),
    .row_ready_out(f_ready), .row_address_in(f_addr_in),
    .rgb_top_out(f_top), .rgb_bot_out(f_bot), .bclk_out(f_bclk),
    .latch_out(f_latch), .oe_n_out(f_oe_n), .addr_out(f_addr_out)
  );

  typedef struct {
    int         kind;
    logic [5:0] rgb;
    int         addr;
    int         len;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
    else $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
  endtask

  function automatic logic [6*N-1:0] mk_row(input logic [N-1:0] tr, tg, tbl, br, bg, bb);
    return {tr, tg, tbl, br, bg, bb};
  endfunction

  // Expected panel traffic for one row: columns 63..0, then latch, then display.
  task automatic push_row(input logic [6*N-1:0] row, input int addr);
    exp_t e;
    logic [N-1:0] tr, tg, tbl, br, bg, bb;
    {tr, tg, tbl, br, bg, bb} = row;
    for (int k = 0; k < N; k++) begin
      int c;
      c = N - 1 - k;
      e.kind = K_COL; e.addr = 0; e.len = 0;
      e.rgb  = {bb[c], bg[c], br[c], tbl[c], tg[c], tr[c]};
      exp_q.push_back(e);
    end
    e.kind = K_LATCH; e.rgb = '0; e.addr = addr; e.len = 2 * H;
    exp_q.push_back(e);
    e.kind = K_DISP; e.addr = 0; e.len = D;
    exp_q.push_back(e);
  endtask

  task automatic pop_exp(input int kind, output exp_t e, output bit ok);
    ok = 1'b0;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_output: kind %0d seen, required nothing (cycle %0d)", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      ok = (e.kind == kind);
      if (!ok) check("output_kind", kind, e.kind);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    bit ok;
    logic prev_bclk, prev_latch, prev_oe;
    logic [3:0] prev_addr;
    int lat_len, disp_len;
    bit lat_bad, disp_bad;
    prev_bclk = 1'b0; prev_latch = 1'b0; prev_oe = 1'b1; prev_addr = '0;
    lat_len = 0; disp_len = 0; lat_bad = 1'b0; disp_bad = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_in) begin
        lat_len = 0; disp_len = 0; lat_bad = 1'b0; disp_bad = 1'b0;
      end else begin
        if (bclk_out && !prev_bclk) begin
          pop_exp(K_COL, e, ok);
          if (ok) check("column_rgb", {rgb_bot_out, rgb_top_out}, e.rgb);
        end
        if (latch_out) begin
          lat_len++;
          if (bclk_out || !oe_n_out || rgb_top_out != 0 || rgb_bot_out != 0) lat_bad = 1'b1;
        end else if (prev_latch) begin
          pop_exp(K_LATCH, e, ok);
          if (ok) begin
            check("latch_len", lat_len, e.len);
            check("latch_addr", addr_out, e.addr);
            check("latch_clean", lat_bad, 0);
          end
          lat_len = 0; lat_bad = 1'b0;
        end
        if (!oe_n_out) begin
          disp_len++;
          if (latch_out || bclk_out || rgb_top_out != 0 || rgb_bot_out != 0 || addr_out != prev_addr)
            disp_bad = 1'b1;
        end else if (!prev_oe) begin
          pop_exp(K_DISP, e, ok);
          if (ok) begin
            check("display_len", disp_len, e.len);
            check("display_clean", disp_bad, 0);
          end
          disp_len = 0; disp_bad = 1'b0;
        end
      end
      prev_bclk = bclk_out; prev_latch = latch_out; prev_oe = oe_n_out; prev_addr = addr_out;
    end
  end

  // Called between edges; returns just after the accepting edge.
  task automatic send_row(input logic [6*N-1:0] row, input logic [3:0] addr,
                          input bit hold_valid, output int acc_cyc);
    int w;
    row_in = row; row_address_in = addr; row_valid_in = 1'b1;
    w = 0;
    while (!row_ready_out && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    if (!row_ready_out) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: ready 0 after %0d cycles, required 1", w);
      row_valid_in = 1'b0;
      acc_cyc = -1;
      return;
    end
    push_row(row, addr);
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!hold_valid) row_valid_in = 1'b0;
  endtask

  task automatic wait_done(input string name, input int acc_cyc, input int period);
    int w;
    w = 0;
    while (!row_ready_out && w < 3000) begin
      @(posedge clk); #1;
      w++;
    end
    check(name, cyc - acc_cyc, period);
    w = 0;
    while (exp_q.size() != 0 && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t_prev, w;
    logic [6*N-1:0] r;
    reset_in = 1'b1; row_in = '0; row_valid_in = 1'b0; row_address_in = '0;
    f_row = '0; f_valid = 1'b0; f_addr_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", row_ready_out, 0);
    check("reset_bclk", bclk_out, 0);
    check("reset_latch", latch_out, 0);
    check("reset_oe_n", oe_n_out, 1);
    check("reset_addr", addr_out, 0);
    check("reset_rgb", {rgb_bot_out, rgb_top_out}, 0);
    reset_in = 1'b0;
    #1;
    check("ready_after_reset", row_ready_out, 1);

    // All-ones red row at address 5
    send_row(mk_row('1, '0, '0, '1, '0, '0), 4'd5, 1'b0, t);
    wait_done("period_red", t, 2*H*N + 2*H + D);

    // Only top.green column 63 set
    r = mk_row('0, {1'b1, {(N-1){1'b0}}}, '0, '0, '0, '0);
    send_row(r, 4'd9, 1'b0, t);
    wait_done("period_walk", t, 516);

    // Mixed pattern on all six planes
    r = mk_row(64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_F0F0_0F0F, 64'hA5A5_A5A5_5A5A_5A5A,
               64'hFEDC_BA98_7654_3210, 64'h8000_0000_0000_0001, 64'h00FF_00FF_FF00_FF00);
    send_row(r, 4'd12, 1'b0, t);
    wait_done("period_mixed", t, 516);

    // Valid pulse while shifting must be ignored
    send_row(mk_row('0, '0, '1, '0, '0, '0), 4'd3, 1'b0, t);
    repeat (20) @(posedge clk);
    #1;
    row_in = mk_row('1, '1, '1, '1, '1, '1); row_address_in = 4'd7; row_valid_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    row_valid_in = 1'b0;
    wait_done("period_ignore", t, 516);
    repeat (20) @(posedge clk);
    #1;
    check("no_second_row_shifted", bclk_out | latch_out | !oe_n_out, 0);

    // Back-to-back with valid held: addresses 0..15 then 0
    t_prev = 0;
    for (int i = 0; i < 17; i++) begin
      r = mk_row(64'(i) << i, ~(64'(i) << 2*i), '0, 64'hC3C3_0000_0000_0000 >> i, '0, 64'(1) << (63 - i));
      send_row(r, 4'(i % 16), 1'b1, t);
      if (i > 0) check("accept_interval", t - t_prev, 517);
      t_prev = t;
    end
    row_valid_in = 1'b0;
    wait_done("period_b2b_last", t, 516);

    // Reset during column 30
    send_row(mk_row('1, '0, '1, '0, '1, '0), 4'd10, 1'b0, t);
    repeat (133) @(posedge clk);
    #1;
    check("cols_before_reset", exp_q.size(), 33);
    reset_in = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    check("midrow_reset_ready", row_ready_out, 0);
    check("midrow_reset_bclk", bclk_out, 0);
    check("midrow_reset_latch", latch_out, 0);
    check("midrow_reset_oe_n", oe_n_out, 1);
    check("midrow_reset_addr", addr_out, 0);
    check("midrow_reset_rgb", {rgb_bot_out, rgb_top_out}, 0);
    @(posedge clk); #1;
    reset_in = 1'b0;
    #1;
    check("ready_after_midrow_reset", row_ready_out, 1);
    r = mk_row(64'hDEAD_BEEF_0000_FFFF, '0, 64'h1, '0, 64'h8000_0000_0000_0000, 64'h1234_5678_9ABC_DEF0);
    send_row(r, 4'd2, 1'b0, t);
    wait_done("period_after_reset", t, 516);

    // Fast shift clock: HALF = 1
    f_row = mk_row('0, '1, '0, '0, '0, '1);
    f_addr_in = 4'd6;
    check("fast_ready", f_ready, 1);
    f_valid = 1'b1;
    @(posedge clk); #1;
    f_valid = 1'b0;
    t = cyc;
    for (int i = 0; i < 8; i++) begin
      check("fast_bclk", f_bclk, i % 2);
      check("fast_rgb", {f_bot, f_top}, 6'b100_010);
      @(posedge clk); #1;
    end
    w = 0;
    while (!f_ready && w < 1000) begin
      @(posedge clk); #1;
      w++;
    end
    check("fast_period", cyc - t, 130 + FD);
    check("fast_addr", f_addr_out, 6);

    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_display_row_driver.md
LED_DISPLAY_ROW_DRIVER -- requirements
Module: led_display_row_driver

Interface
REQ-001 SHALL have parameter SYS_CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BCLK_FREQ, default 21_000_000, target panel shift-clock frequency in Hz.
REQ-003 SHALL have parameter NUM_COL_PIXELS, default 64, number of columns per row.
REQ-004 SHALL have parameter DISPLAY_CYCLES, default 256, number of system cycles the panel is enabled per row.
REQ-005 SHALL have port clk_in, input, 1 bit, the single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset_in, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port row_in, input, rgb_row_t (6*NUM_COL_PIXELS bits: top/bot, each red/green/blue), the row pixel data.
REQ-008 SHALL have port row_valid_in, input, 1 bit, meaning row_in and row_address_in are valid.
REQ-009 SHALL have port row_ready_out, output, 1 bit, meaning the block accepts a row this cycle.
REQ-010 SHALL have port row_address_in, input, 4 bits, the panel row pair index 0-15.
REQ-011 SHALL have port rgb_top_out, output, 3 bits, top-half serial data: [0] red, [1] green, [2] blue.
REQ-012 SHALL have port rgb_bot_out, output, 3 bits, bottom-half serial data with the same bit order.
REQ-013 SHALL have port bclk_out, output, 1 bit, panel shift clock; the panel samples data on its rising edge.
REQ-014 SHALL have port latch_out, output, 1 bit, panel latch strobe, active high.
REQ-015 SHALL have port oe_n_out, output, 1 bit, panel output enable, active low.
REQ-016 SHALL have port addr_out, output, 4 bits, panel row address.

Function
REQ-017 SHALL derive HALF = max(1, SYS_CLK_FREQ/(2*BCLK_FREQ)) using integer division; HALF is 2 at the defaults.
REQ-018 SHALL implement an FSM with states IDLE, SHIFT, LATCH and DISPLAY.
REQ-019 SHALL drive row_ready_out high only in IDLE and not during reset.
REQ-020 SHALL accept a row only at a rising edge where row_valid_in and row_ready_out are both high, capturing row_in and row_address_in, then move to SHIFT.
REQ-021 SHALL ignore row_valid_in and input data in every state other than IDLE.
REQ-022 In SHIFT, SHALL present each column for 2*HALF cycles: bclk_out low for the first HALF cycles, high for the last HALF cycles, data stable for the whole column.
REQ-023 SHALL shift column NUM_COL_PIXELS-1 first and column 0 last; column c drives rgb_top_out = {top.blue[c], top.green[c], top.red[c]} and the equivalent for the bottom half.
REQ-024 After the last column's high phase, SHALL enter LATCH with bclk_out low.
REQ-025 On entry to LATCH, SHALL load addr_out with the captured address, then hold latch_out high for 2*HALF cycles.
REQ-026 In DISPLAY, SHALL hold oe_n_out low for exactly DISPLAY_CYCLES cycles, then return to IDLE.
REQ-027 SHALL hold oe_n_out high in all states except DISPLAY; addr_out changes only while oe_n_out is high.
REQ-028 SHALL use a column counter wide enough for NUM_COL_PIXELS-1 that wraps to 0 on entry to SHIFT.
REQ-029 Row period from the accept edge to the next IDLE SHALL be 2*HALF*NUM_COL_PIXELS + 2*HALF + DISPLAY_CYCLES cycles: 516 at the defaults.
REQ-030 rgb_*_out SHALL be 0 outside SHIFT.

Reset
REQ-031 While reset_in is high at a rising edge, SHALL force state IDLE, row_ready_out 0, bclk_out 0, latch_out 0, oe_n_out 1, addr_out 0, rgb_*_out 0 and counters 0.
REQ-032 Reset mid-row SHALL discard the captured row; row_ready_out SHALL be 1 on the first cycle after reset_in falls.

Verification
REQ-033 Accept an all-ones red row at address 5 -> 64 bclk_out rising edges with rgb_top_out = rgb_bot_out = 3'b001 throughout, then latch_out high 4 cycles, addr_out = 5, oe_n_out low 256 cycles.
REQ-034 Walking pattern with top.green bit 63 = 1 only -> rgb_top_out[1] = 1 on the first shifted column only.
REQ-035 Hold row_valid_in high continuously, addresses 0..15 then 0 -> back-to-back accepts every 517 cycles, addr_out sequence 0..15,0, no oe_n_out low during SHIFT or LATCH.
REQ-036 Pulse row_valid_in during SHIFT -> ignored; no second row is shifted.
REQ-037 Assert reset_in at column 30 -> next cycle all outputs at reset values; row_ready_out = 1 the cycle after reset_in falls; a fresh row then shifts all 64 columns.
REQ-038 Parameter override BCLK_FREQ = 50_000_000 -> HALF = 1, bclk_out toggles every cycle, row period 130 + DISPLAY_CYCLES.
